// File: rtl/trap_ctrl_unit_pkg.sv
// Shared definitions for the trap controller: CSR addresses, mstatus bit
// positions, privilege encodings and the flush FSM state type.
package trap_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEDELEG = 12'h302;
    localparam logic [11:0] CSR_MIDELEG = 12'h303;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;
    localparam logic [11:0] CSR_MIP     = 12'h344;
    localparam logic [11:0] CSR_SSTATUS = 12'h100;
    localparam logic [11:0] CSR_STVEC   = 12'h105;
    localparam logic [11:0] CSR_SEPC    = 12'h141;
    localparam logic [11:0] CSR_SCAUSE  = 12'h142;
    localparam logic [11:0] CSR_STVAL   = 12'h143;

    localparam int MS_SIE    = 1;
    localparam int MS_MIE    = 3;
    localparam int MS_SPIE   = 5;
    localparam int MS_MPIE   = 7;
    localparam int MS_SPP    = 8;
    localparam int MS_MPP_LO = 11;
    localparam int MS_MPP_HI = 12;

    localparam logic [1:0] PRIV_U = 2'd0;
    localparam logic [1:0] PRIV_S = 2'd1;
    localparam logic [1:0] PRIV_M = 2'd3;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } fsm_state_e;

endpackage

// File: rtl/trap_ctrl_unit_int_pend_arb.sv
// Interrupt pending array with per-source level/edge capture and a
// highest-index-wins arbiter over the enabled candidates.
module int_pend_arb
    import trap_pkg::*;
#(
    parameter int                 NUM_INT   = 16,
    parameter logic [NUM_INT-1:0] EDGE_MASK = '0,
    parameter int                 IDX_W     = (NUM_INT > 1) ? $clog2(NUM_INT) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_INT-1:0] int_src,
    input  logic [NUM_INT-1:0] en_vec,
    input  logic [NUM_INT-1:0] clr_vec,
    output logic [NUM_INT-1:0] mip,
    output logic [IDX_W-1:0]   win_idx,
    output logic               win_vld
);

    logic [NUM_INT-1:0] src_q, src_d;
    logic [NUM_INT-1:0] mip_q, mip_d;
    logic [NUM_INT-1:0] edge_s;
    logic [NUM_INT-1:0] cand_s;

    // Next pending state: level sources mirror the line, edge sources latch a rising edge (set beats clear).
    always_comb begin
        src_d  = int_src;
        edge_s = int_src & ~src_q;
        mip_d  = (EDGE_MASK & ((mip_q & ~clr_vec) | edge_s)) | (~EDGE_MASK & int_src);
    end

    // Edge history and pending registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            src_q <= '0;
            mip_q <= '0;
        end else begin
            src_q <= src_d;
            mip_q <= mip_d;
        end
    end

    // Highest enabled pending index wins; later iterations overwrite lower hits.
    always_comb begin
        cand_s  = mip_q & en_vec;
        win_idx = '0;
        win_vld = 1'b0;
        for (int i = 0; i < NUM_INT; i++) begin
            win_idx = cand_s[i] ? IDX_W'(i) : win_idx;
            win_vld = cand_s[i] | win_vld;
        end
    end

    assign mip = mip_q;

endmodule

// File: rtl/trap_ctrl_unit.sv
// Trap controller: M/S trap CSRs, privilege, interrupt selection and the
// registered flush/redirect handshake towards IF.
module trap_ctrl_unit
    import trap_pkg::*;
#(
    parameter int                 XLEN      = 64,
    parameter int                 NUM_INT   = 16,
    parameter logic [NUM_INT-1:0] EDGE_MASK = '0,
    parameter logic [XLEN-1:0]    RESET_VEC = '0,
    parameter bit                 VEC_EN    = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_INT-1:0] int_src,
    input  logic               valid,
    input  logic [XLEN-1:0]    ins_pc,
    input  logic               exc_vld,
    input  logic [4:0]         exc_cause,
    input  logic [XLEN-1:0]    exc_tval,
    input  logic               int_acc,
    input  logic               pc_jmp,
    input  logic [XLEN-1:0]    new_pc,
    input  logic               m_ret,
    input  logic               s_ret,
    input  logic               csr_write,
    input  logic [11:0]        csr_index,
    input  logic [XLEN-1:0]    data_csr,
    input  logic [11:0]        id_csr_index,
    output logic [XLEN-1:0]    csr_data,
    output logic               int_req,
    output logic               pip_flush,
    output logic [XLEN-1:0]    flush_pc,
    input  logic               if_ack,
    output logic [1:0]         priv,
    output logic               busy
);

    localparam int IDX_W = (NUM_INT > 1) ? $clog2(NUM_INT) : 1;

    fsm_state_e         state_q, state_d;
    logic [1:0]         priv_q, priv_d, st_mpp_q, st_mpp_d;
    logic               st_mie_q, st_mie_d, st_sie_q, st_sie_d, st_mpie_q, st_mpie_d;
    logic               st_spie_q, st_spie_d, st_spp_q, st_spp_d;
    logic               pip_flush_q, pip_flush_d, busy_q, busy_d;
    logic [XLEN-1:0]    medeleg_q, medeleg_d, mtvec_q, mtvec_d, stvec_q, stvec_d;
    logic [XLEN-1:0]    mepc_q, mepc_d, sepc_q, sepc_d, mcause_q, mcause_d, scause_q, scause_d;
    logic [XLEN-1:0]    mtval_q, mtval_d, stval_q, stval_d, flush_pc_q, flush_pc_d;
    logic [NUM_INT-1:0] mideleg_q, mideleg_d, csr_mie_q, csr_mie_d;

    logic [NUM_INT-1:0] mip_s, clr_vec_s, deleg_s, en_vec_s;
    logic [IDX_W-1:0]   win_idx_s;
    logic               win_vld_s, priv_lt_m_s, m_en_s, s_en_s, to_s_s, flush_s;
    logic [XLEN-1:0]    trap_code_s, trap_cause_s, trap_epc_s, trap_tval_s;
    logic [XLEN-1:0]    tvec_sel_s, vec_base_s, trap_pc_s, mstatus_s, sstatus_s;
    logic [XLEN-1:0]    mie_ext_s, mip_ext_s, mideleg_ext_s;

    int_pend_arb #(
        .NUM_INT   (NUM_INT),
        .EDGE_MASK (EDGE_MASK),
        .IDX_W     (IDX_W)
    ) u_int_pend_arb (
        .clk     (clk),
        .rst     (rst),
        .int_src (int_src),
        .en_vec  (en_vec_s),
        .clr_vec (clr_vec_s),
        .mip     (mip_s),
        .win_idx (win_idx_s),
        .win_vld (win_vld_s)
    );

    // Per-source interrupt enable: delegated sources obey S rules, the rest M rules.
    always_comb begin
        priv_lt_m_s = (priv_q != PRIV_M);
        m_en_s      = priv_lt_m_s | st_mie_q;
        s_en_s      = (priv_q == PRIV_U) | ((priv_q == PRIV_S) & st_sie_q);
        deleg_s     = mideleg_q & {NUM_INT{priv_lt_m_s}};
        en_vec_s    = csr_mie_q & ((deleg_s & {NUM_INT{s_en_s}}) | (~deleg_s & {NUM_INT{m_en_s}}));
        int_req     = win_vld_s & (state_q == ST_RUN);
    end

    // Trap target, cause, epc and vector for whichever trap the current commit would take.
    always_comb begin
        to_s_s       = exc_vld ? (medeleg_q[exc_cause] & priv_lt_m_s)
                               : (mideleg_q[win_idx_s] & priv_lt_m_s);
        trap_code_s  = exc_vld ? XLEN'(exc_cause) : XLEN'(win_idx_s);
        trap_cause_s = exc_vld ? trap_code_s : (trap_code_s | (XLEN'(1) << (XLEN - 1)));
        trap_epc_s   = exc_vld ? ins_pc : (pc_jmp ? new_pc : ins_pc + XLEN'(4));
        trap_tval_s  = exc_vld ? exc_tval : '0;
        tvec_sel_s   = to_s_s ? stvec_q : mtvec_q;
        vec_base_s   = {tvec_sel_s[XLEN-1:2], 2'b00};
        trap_pc_s    = (VEC_EN && (tvec_sel_s[1:0] == 2'b01) && !exc_vld)
                       ? vec_base_s + (trap_code_s << 2) : vec_base_s;
    end

    // Combinational CSR read port for ID; unmapped addresses read zero.
    always_comb begin
        mstatus_s                       = '0;
        mstatus_s[MS_SIE]               = st_sie_q;
        mstatus_s[MS_MIE]               = st_mie_q;
        mstatus_s[MS_SPIE]              = st_spie_q;
        mstatus_s[MS_MPIE]              = st_mpie_q;
        mstatus_s[MS_SPP]               = st_spp_q;
        mstatus_s[MS_MPP_HI:MS_MPP_LO]  = st_mpp_q;
        sstatus_s                       = '0;
        sstatus_s[MS_SIE]               = st_sie_q;
        sstatus_s[MS_SPIE]              = st_spie_q;
        sstatus_s[MS_SPP]               = st_spp_q;
        mie_ext_s                       = '0;
        mie_ext_s[NUM_INT-1:0]          = csr_mie_q;
        mip_ext_s                       = '0;
        mip_ext_s[NUM_INT-1:0]          = mip_s;
        mideleg_ext_s                   = '0;
        mideleg_ext_s[NUM_INT-1:0]      = mideleg_q;
        case (id_csr_index)
            CSR_MSTATUS: csr_data = mstatus_s;
            CSR_MEDELEG: csr_data = medeleg_q;
            CSR_MIDELEG: csr_data = mideleg_ext_s;
            CSR_MIE:     csr_data = mie_ext_s;
            CSR_MTVEC:   csr_data = mtvec_q;
            CSR_MEPC:    csr_data = mepc_q;
            CSR_MCAUSE:  csr_data = mcause_q;
            CSR_MTVAL:   csr_data = mtval_q;
            CSR_MIP:     csr_data = mip_ext_s;
            CSR_SSTATUS: csr_data = sstatus_s;
            CSR_STVEC:   csr_data = stvec_q;
            CSR_SEPC:    csr_data = sepc_q;
            CSR_SCAUSE:  csr_data = scause_q;
            CSR_STVAL:   csr_data = stval_q;
            default:     csr_data = '0;
        endcase
    end

    // Commit action selection, CSR updates and flush FSM next state.
    always_comb begin
        state_d = state_q;       priv_d = priv_q;         st_mpp_d = st_mpp_q;
        st_mie_d = st_mie_q;     st_sie_d = st_sie_q;     st_mpie_d = st_mpie_q;
        st_spie_d = st_spie_q;   st_spp_d = st_spp_q;     pip_flush_d = pip_flush_q;
        busy_d = busy_q;         medeleg_d = medeleg_q;   mideleg_d = mideleg_q;
        csr_mie_d = csr_mie_q;   mtvec_d = mtvec_q;       stvec_d = stvec_q;
        mepc_d = mepc_q;         sepc_d = sepc_q;         mcause_d = mcause_q;
        scause_d = scause_q;     mtval_d = mtval_q;       stval_d = stval_q;
        flush_pc_d = flush_pc_q; clr_vec_s = '0;          flush_s = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (valid && (exc_vld || (int_req && int_acc))) begin
                    flush_s    = 1'b1;
                    flush_pc_d = trap_pc_s;
                    clr_vec_s  = exc_vld ? '0 : (NUM_INT'(1) << win_idx_s);
                    if (to_s_s) begin
                        sepc_d = trap_epc_s; scause_d = trap_cause_s; stval_d = trap_tval_s;
                        st_spie_d = st_sie_q; st_sie_d = 1'b0; st_spp_d = priv_q[0]; priv_d = PRIV_S;
                    end else begin
                        mepc_d = trap_epc_s; mcause_d = trap_cause_s; mtval_d = trap_tval_s;
                        st_mpie_d = st_mie_q; st_mie_d = 1'b0; st_mpp_d = priv_q; priv_d = PRIV_M;
                    end
                end else if (valid && m_ret) begin
                    flush_s = 1'b1; flush_pc_d = mepc_q;
                    priv_d = st_mpp_q; st_mie_d = st_mpie_q; st_mpie_d = 1'b1; st_mpp_d = PRIV_U;
                end else if (valid && s_ret) begin
                    flush_s = 1'b1; flush_pc_d = sepc_q;
                    priv_d = {1'b0, st_spp_q}; st_sie_d = st_spie_q; st_spie_d = 1'b1; st_spp_d = 1'b0;
                end else if (valid && pc_jmp) begin
                    flush_s = 1'b1; flush_pc_d = new_pc;
                end else if (valid && csr_write) begin
                    case (csr_index)
                        CSR_MSTATUS: begin
                            st_sie_d  = data_csr[MS_SIE];  st_mie_d  = data_csr[MS_MIE];
                            st_spie_d = data_csr[MS_SPIE]; st_mpie_d = data_csr[MS_MPIE];
                            st_spp_d  = data_csr[MS_SPP];  st_mpp_d  = data_csr[MS_MPP_HI:MS_MPP_LO];
                        end
                        CSR_SSTATUS: begin
                            st_sie_d  = data_csr[MS_SIE];  st_spie_d = data_csr[MS_SPIE];
                            st_spp_d  = data_csr[MS_SPP];
                        end
                        CSR_MEDELEG: medeleg_d = data_csr;
                        CSR_MIDELEG: mideleg_d = data_csr[NUM_INT-1:0];
                        CSR_MIE:     csr_mie_d = data_csr[NUM_INT-1:0];
                        CSR_MTVEC:   mtvec_d   = data_csr;
                        CSR_MEPC:    mepc_d    = {data_csr[XLEN-1:2], 2'b00};
                        CSR_MCAUSE:  mcause_d  = data_csr;
                        CSR_MTVAL:   mtval_d   = data_csr;
                        CSR_MIP:     clr_vec_s = ~data_csr[NUM_INT-1:0];
                        CSR_STVEC:   stvec_d   = data_csr;
                        CSR_SEPC:    sepc_d    = {data_csr[XLEN-1:2], 2'b00};
                        CSR_SCAUSE:  scause_d  = data_csr;
                        CSR_STVAL:   stval_d   = data_csr;
                        default:     clr_vec_s = '0;
                    endcase
                end else begin
                    flush_s = 1'b0;
                end
            end
            ST_FLUSH: begin
                if (if_ack) begin
                    state_d = ST_RUN; pip_flush_d = 1'b0; busy_d = 1'b0;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            default: begin
                state_d = ST_RUN; pip_flush_d = 1'b0; busy_d = 1'b0;
            end
        endcase
        state_d     = flush_s ? ST_FLUSH : state_d;
        pip_flush_d = flush_s | pip_flush_d;
        busy_d      = flush_s | busy_d;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_RUN;     priv_q <= PRIV_M;      st_mpp_q <= PRIV_U;
            st_mie_q <= 1'b0;      st_sie_q <= 1'b0;      st_mpie_q <= 1'b0;
            st_spie_q <= 1'b0;     st_spp_q <= 1'b0;      pip_flush_q <= 1'b0;
            busy_q <= 1'b0;        medeleg_q <= '0;       mideleg_q <= '0;
            csr_mie_q <= '0;       mtvec_q <= RESET_VEC;  stvec_q <= '0;
            mepc_q <= '0;          sepc_q <= '0;          mcause_q <= '0;
            scause_q <= '0;        mtval_q <= '0;         stval_q <= '0;
            flush_pc_q <= '0;
        end else begin
            state_q <= state_d;       priv_q <= priv_d;         st_mpp_q <= st_mpp_d;
            st_mie_q <= st_mie_d;     st_sie_q <= st_sie_d;     st_mpie_q <= st_mpie_d;
            st_spie_q <= st_spie_d;   st_spp_q <= st_spp_d;     pip_flush_q <= pip_flush_d;
            busy_q <= busy_d;         medeleg_q <= medeleg_d;   mideleg_q <= mideleg_d;
            csr_mie_q <= csr_mie_d;   mtvec_q <= mtvec_d;       stvec_q <= stvec_d;
            mepc_q <= mepc_d;         sepc_q <= sepc_d;         mcause_q <= mcause_d;
            scause_q <= scause_d;     mtval_q <= mtval_d;       stval_q <= stval_d;
            flush_pc_q <= flush_pc_d;
        end
    end

    assign pip_flush = pip_flush_q;
    assign flush_pc  = flush_pc_q;
    assign priv      = priv_q;
    assign busy      = busy_q;

endmodule
